keypad_entry: RTL and testbench

Button-entry front end for the combination lock, and the input-side counterpart of the seven-segment display driver. It synchronises and debounces the five Nexys-4 push buttons, and lets the user edit a 4-digit hex code one nibble at a time. It drives `value`/`point` straight into the display driver. On centre press it presents the code to the lock FSM through a valid/ack handshake.

---
 rtl/keypad_entry.sv | 135 +++++++++++++
 tb/tb_keypad_entry.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: synchronises and debounces five push buttons, edits a 4-nibble hex code
// and hands the finished code to the lock FSM over a valid/ack handshake.
`default_nettype none

module keypad_entry #(
  parameter logic [15:0] DB_COUNT = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  input  logic        codeAck,
  output logic [15:0] value,
  output logic [3:0]  point,
  output logic [15:0] code,
  output logic        codeValid
);

  typedef enum logic [0:0] {
    EDIT = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [15:0] DB_LAST = DB_COUNT - 16'd1;

  // Bit order sets action priority: C, U, D, L, R.
  logic [4:0] raw;
  logic [4:0] press;

  assign raw = {btnR, btnL, btnD, btnU, btnC};

  generate
    for (genvar i = 0; i < 5; i++) begin : g_btn
      logic        s1;
      logic        s2;
      logic        db;
      logic        db_d;
      logic [15:0] cnt;

      always_ff @(posedge clock) begin
        if (!reset) begin
          s1   <= 1'b0;
          s2   <= 1'b0;
          db   <= 1'b0;
          db_d <= 1'b0;
          cnt  <= 16'd0;
        end else begin
          s1   <= raw[i];
          s2   <= s1;
          db_d <= db;
          if (s2 != db) begin
            if (cnt == DB_LAST) begin
              db  <= s2;
              cnt <= 16'd0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            cnt <= 16'd0;
          end
        end
      end

      assign press[i] = db & ~db_d;
    end
  endgenerate

  state_t      state, state_nx;
  logic [1:0]  cursor, cursor_nx;
  logic [15:0] value_nx;
  logic [15:0] code_nx;
  logic        valid_nx;
  logic [3:0]  nib_lsb;

  assign nib_lsb = {cursor, 2'b00};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= EDIT;
      cursor    <= 2'd0;
      value     <= 16'h0000;
      code      <= 16'h0000;
      codeValid <= 1'b0;
    end else begin
      state     <= state_nx;
      cursor    <= cursor_nx;
      value     <= value_nx;
      code      <= code_nx;
      codeValid <= valid_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cursor_nx = cursor;
    value_nx  = value;
    code_nx   = code;
    valid_nx  = codeValid;
    case (state)
      EDIT: begin
        if (press[0]) begin
          code_nx  = value;
          valid_nx = 1'b1;
          state_nx = WAIT;
        end else if (press[1]) begin
          value_nx[nib_lsb +: 4] = value[nib_lsb +: 4] + 4'd1;
        end else if (press[2]) begin
          value_nx[nib_lsb +: 4] = value[nib_lsb +: 4] - 4'd1;
        end else if (press[3]) begin
          cursor_nx = cursor + 2'd1;
        end else if (press[4]) begin
          cursor_nx = cursor - 2'd1;
        end
      end
      WAIT: begin
        // Presses here are deliberately dropped rather than queued.
        if (codeAck) begin
          valid_nx  = 1'b0;
          value_nx  = 16'h0000;
          cursor_nx = 2'd0;
          state_nx  = EDIT;
        end
      end
      default: state_nx = EDIT;
    endcase
  end

  assign point = (state == WAIT) ? 4'b1111 : ~(4'b0001 << cursor);

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// Randomised self-checking bench for keypad_entry against a press-level behavioural model.
`default_nettype none

module tb_keypad_entry;

  localparam logic [15:0] DB = 16'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  btns  = 5'd0;   // {R, L, D, U, C}
  logic        codeAck = 1'b0;
  logic [15:0] value;
  logic [3:0]  point;
  logic [15:0] code;
  logic        codeValid;

  int n_checks = 0;
  int n_errors = 0;

  keypad_entry #(.DB_COUNT(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .btnU      (btns[1]),
    .btnD      (btns[2]),
    .btnL      (btns[3]),
    .btnR      (btns[4]),
    .btnC      (btns[0]),
    .codeAck   (codeAck),
    .value     (value),
    .point     (point),
    .code      (code),
    .codeValid (codeValid)
  );

  always #5 clock = ~clock;

  // Reference model: one action per accepted press.
  logic [3:0]  mval [4];
  int          mcur;
  bit          mwait;
  logic [15:0] mcode;

  function automatic logic [15:0] mpack();
    return {mval[3], mval[2], mval[1], mval[0]};
  endfunction

  function automatic logic [3:0] mpoint();
    if (mwait) return 4'b1111;
    return 4'b1111 ^ 4'(1 << mcur);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mval[k] = 4'h0;
    mcur  = 0;
    mwait = 1'b0;
    mcode = 16'h0000;
  endtask

  task automatic model_press(input logic [4:0] m);
    if (mwait || m == 5'd0) return;
    if (m[0]) begin
      mcode = mpack();
      mwait = 1'b1;
    end else if (m[1]) mval[mcur] = mval[mcur] + 4'd1;
    else if (m[2]) mval[mcur] = mval[mcur] - 4'd1;
    else if (m[3]) mcur = (mcur + 1) % 4;
    else mcur = (mcur + 3) % 4;
  endtask

  task automatic model_ack();
    if (!mwait) return;
    for (int k = 0; k < 4; k++) mval[k] = 4'h0;
    mcur  = 0;
    mwait = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".value"}, 32'(value), 32'(mpack()));
    check({tag, ".point"}, 32'(point), 32'(mpoint()));
    check({tag, ".code"}, 32'(code), 32'(mcode));
    check({tag, ".valid"}, 32'(codeValid), 32'(mwait));
  endtask

  task automatic do_reset(input int edges);
    @(negedge clock);
    reset   = 1'b0;
    codeAck = 1'b0;
    repeat (edges) begin
      btns = 5'($urandom);
      @(negedge clock);
    end
    btns  = 5'd0;
    reset = 1'b1;
    model_reset();
  endtask

  // Mask held for `hold` sampled cycles then released for 10; counts as a press if long enough.
  task automatic press_mask(input logic [4:0] m, input int hold);
    @(negedge clock);
    btns = m;
    repeat (hold) @(negedge clock);
    btns = 5'd0;
    repeat (10) @(negedge clock);
    if (hold >= int'(DB)) model_press(m);
  endtask

  task automatic pulse_ack();
    @(negedge clock);
    codeAck = 1'b1;
    @(negedge clock);
    codeAck = 1'b0;
    model_ack();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] m;
    model_reset();

    // Reset with buttons toggling.
    do_reset(3);
    check_all("reset");
    repeat (12) @(negedge clock);
    check_all("post_reset");

    // First update must land exactly at the 7th rising edge after the button is set.
    btns = 5'b00010;
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("u_before_E6", 32'(value), 32'h0);
    @(negedge clock);
    check("u_at_E6", 32'(value), 32'h1);
    repeat (3) @(negedge clock);
    btns = 5'd0;
    repeat (10) @(negedge clock);
    model_press(5'b00010);
    press_mask(5'b00010, 10);
    press_mask(5'b00010, 10);
    check("three_up", 32'(value), 32'h0003);
    press_mask(5'b01000, 10);
    press_mask(5'b00100, 10);
    check("down_digit1", 32'(value), 32'h00F3);
    check_all("incr");

    // Glitch, long hold, simultaneous U+D.
    press_mask(5'b00010, 3);
    check_all("glitch");
    press_mask(5'b00010, 200);
    check_all("long_hold");
    press_mask(5'b00110, 10);
    check_all("u_and_d");

    // Cursor wrap from a clean state.
    do_reset(1);
    press_mask(5'b10000, 10);
    check("wrap_point", 32'(point), 32'b0111);
    press_mask(5'b00010, 10);
    press_mask(5'b00010, 10);
    check("wrap_value", 32'(value), 32'h2000);
    press_mask(5'b01000, 10);
    check("wrap_back", 32'(point), 32'b1110);
    check_all("wrap");

    // Enter 1234 and submit.
    do_reset(1);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4 - d; k++) press_mask(5'b00010, 10);
      if (d < 3) press_mask(5'b01000, 10);
    end
    check("entered", 32'(value), 32'h1234);
    @(negedge clock);
    btns = 5'b00001;
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("c_before_E6", 32'(codeValid), 32'h0);
    @(negedge clock);
    check("c_valid_E6", 32'(codeValid), 32'h1);
    check("c_code_E6", 32'(code), 32'h1234);
    repeat (3) @(negedge clock);
    btns = 5'd0;
    repeat (10) @(negedge clock);
    model_press(5'b00001);
    press_mask(5'b00010, 10);
    press_mask(5'b00010, 10);
    repeat (5) @(negedge clock);
    check_all("wait_hold");
    @(negedge clock);
    codeAck = 1'b1;
    @(negedge clock);
    codeAck = 1'b0;
    model_ack();
    check("ack_valid", 32'(codeValid), 32'h0);
    check("ack_value", 32'(value), 32'h0000);
    check("ack_point", 32'(point), 32'b1110);
    check_all("after_ack");

    // Randomised press/ack traffic.
    for (int it = 0; it < 60; it++) begin
      if (mwait && $urandom_range(0, 2) == 0) begin
        pulse_ack();
      end else if ($urandom_range(0, 7) == 0) begin
        m = 5'($urandom_range(1, 31));
        press_mask(m, 10);
      end else if ($urandom_range(0, 9) == 0) begin
        pulse_ack();
      end else begin
        m = 5'(1 << $urandom_range(0, 4));
        press_mask(m, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 10);
      end
      check_all("rand");
    end

    // Reset mid-WAIT, then a stray ack.
    press_mask(5'b00010, 10);
    if (!mwait) press_mask(5'b00001, 10);
    check("midwait_valid", 32'(codeValid), 32'h1);
    do_reset(1);
    check_all("midwait_reset");
    pulse_ack();
    check_all("stray_ack");
    press_mask(5'b00010, 10);
    check("edit_after", 32'(value), 32'h0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
